alu_bitserial_seq: RTL

- Bit-serial ALU sequencer that drives the control side of the team's 1-bit ALU slice.
- It decodes a 3-bit opcode into the slice's five function lines (op0..op4) and an output-invert flag.
- It presents operand bits r/s LSB-first with a registered carry into c_in, and samples the slice's o/c_out each cycle.
- It assembles a WIDTH-bit result behind a start/busy/done handshake.

---
 rtl/alu_bitserial_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU sequencer: decodes an opcode for an external 1-bit ALU slice and
// walks operands through it LSB-first. Define ALU_SEQ_FLAGS_EN to build zero/ovf flags.
module alu_bitserial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             err,
  output logic             zero,
  output logic             ovf,
  output logic             op0,
  output logic             op1,
  output logic             op2,
  output logic             op3,
  output logic             op4,
  output logic             r,
  output logic             s,
  output logic             c_in,
  input  logic             o,
  input  logic             c_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [4:0]       ops_q, ops_d;
  logic             inv_q, inv_d, arith_q, arith_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_res_q, carry_res_d, err_q, err_d;
`ifdef ALU_SEQ_FLAGS_EN
  logic             zero_q, zero_d, ovf_q, ovf_d;
`endif

  // Opcode decode: {op4..op0}, initial carry, output invert, arithmetic, illegal.
  logic [4:0] dec_ops;
  logic       dec_cin0, dec_inv, dec_arith, dec_illegal;

  // NOTE: every signal written in always_comb gets a default first; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    dec_ops     = 5'b00000;
    dec_cin0    = 1'b0;
    dec_inv     = 1'b0;
    dec_arith   = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      3'b000: begin dec_inv = 1'b1; dec_arith = 1'b1; end
      3'b001: begin dec_ops = 5'b00010; dec_cin0 = 1'b1; dec_inv = 1'b1; dec_arith = 1'b1; end
      3'b010: dec_ops = 5'b01100;
      3'b011: dec_ops = 5'b10100;
      3'b100: dec_ops = 5'b00100;
      3'b101: dec_ops = 5'b00110;
      default: dec_illegal = 1'b1;
    endcase
  end

  logic run;
  logic res_bit;
  assign run     = (state_q == RUN);
  assign res_bit = o ^ inv_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    res_sh_d    = res_sh_q;
    carry_d     = carry_q;
    ops_d       = ops_q;
    inv_d       = inv_q;
    arith_d     = arith_q;
    result_d    = result_q;
    carry_res_d = carry_res_q;
    err_d       = err_q;
`ifdef ALU_SEQ_FLAGS_EN
    zero_d      = zero_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (dec_illegal) begin
            state_d     = DONE;
            result_d    = '0;
            carry_res_d = 1'b0;
            err_d       = 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            zero_d      = 1'b1;
            ovf_d       = 1'b0;
`endif
          end else begin
            state_d = RUN;
            cnt_d   = '0;
            a_sh_d  = a;
            b_sh_d  = b;
            ops_d   = dec_ops;
            inv_d   = dec_inv;
            arith_d = dec_arith;
            carry_d = dec_cin0;
          end
        end
      end
      RUN: begin
        res_sh_d = {res_bit, res_sh_q[WIDTH-1:1]};
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d  = c_out;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          result_d    = res_sh_d;
          carry_res_d = arith_q & c_out;
          err_d       = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
          zero_d      = (res_sh_d == '0);
          // carry_q is the carry into the MSB, c_out the carry out of it.
          ovf_d       = arith_q & (carry_q ^ c_out);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_sh_q    <= '0;
      carry_q     <= 1'b0;
      ops_q       <= '0;
      inv_q       <= 1'b0;
      arith_q     <= 1'b0;
      result_q    <= '0;
      carry_res_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_sh_q    <= res_sh_d;
      carry_q     <= carry_d;
      ops_q       <= ops_d;
      inv_q       <= inv_d;
      arith_q     <= arith_d;
      result_q    <= result_d;
      carry_res_q <= carry_res_d;
      err_q       <= err_d;
`ifdef ALU_SEQ_FLAGS_EN
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  // Slice drives come only from registers, gated to zero outside RUN.
  assign {op4, op3, op2, op1, op0} = run ? ops_q : 5'b00000;
  assign r      = run & a_sh_q[0];
  assign s      = run & b_sh_q[0];
  assign c_in   = run & carry_q;

  assign busy   = run;
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign carry  = carry_res_q;
  assign err    = err_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign zero   = zero_q;
  assign ovf    = ovf_q;
`else
  assign zero   = 1'b0;
  assign ovf    = 1'b0;
`endif

endmodule
